// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Sequencing controller for an external combinational 16-bit ALU.
//             It holds a 4 x 16 register file. It accepts one command at a
//             time, presents registered operands/opcode to the ALU, and
//             captures the ALU result one cycle later. It writes that result
//             back to the register file and offers it on a valid/ready
//             result port.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          clock (rising edge), asynchronous active-high reset
//    cmd_valid/ready   command handshake (ready only while idle)
//    cmd_op            ALU opcode for this command
//    cmd_rd/ra/rb      destination / operand-A / operand-B register indices
//    cmd_imm_sel       1: operand B comes from cmd_imm instead of rf[cmd_rb]
//    cmd_imm           immediate operand
//    alu_a/alu_b       registered operands driven to the ALU
//    alu_sel           registered opcode driven to the ALU
//    alu_out           ALU result (combinational from alu_a/alu_b/alu_sel)
//    alu_carry         ALU carry-out of A+B
//    res_valid/ready   result handshake
//    res_data/carry    captured result and carry (carry only for ADD)
//    op_count          count of handshaken results, wraps at 16 bits
//    dbg_addr/data     combinational register-file read port
// ============================================================================
module alu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [1:0]  cmd_rd,
  input  logic [1:0]  cmd_ra,
  input  logic [1:0]  cmd_rb,
  input  logic        cmd_imm_sel,
  input  logic [15:0] cmd_imm,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [15:0] alu_out,
  input  logic        alu_carry,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_carry,
  output logic [15:0] op_count,
  input  logic [1:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_CLEAR = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] rf_q [4];
  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic [3:0]  alu_sel_q;
  logic [1:0]  rd_q;
  logic [15:0] res_data_q;
  logic        res_carry_q;
  logic [15:0] op_count_q;

  // Next-value terms used by the state machine
  logic [15:0] alu_b_d;
  logic        res_carry_d;
  logic [15:0] op_count_d;

  // Writeback always completes before the next acceptance (minimum spacing
  // is three cycles), so a plain read of rf_q already sees the newest data
  // and no bypass path is needed.
  assign alu_b_d     = cmd_imm_sel ? cmd_imm : rf_q[cmd_rb];
  assign res_carry_d = (alu_sel_q == OP_ADD) ? alu_carry : 1'b0;
  assign op_count_d  = op_count_q + 16'd1;   // natural 16-bit wrap

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= OP_CLEAR;
      rd_q        <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      op_count_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            alu_a_q   <= rf_q[cmd_ra];
            alu_b_q   <= alu_b_d;
            alu_sel_q <= cmd_op;
            rd_q      <= cmd_rd;
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          // The ALU has had a full cycle to settle on the registered operands
          res_data_q  <= alu_out;
          res_carry_q <= res_carry_d;
          rf_q[rd_q]  <= alu_out;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          // Result is held stable until the consumer takes it
          if (res_ready) begin
            op_count_q <= op_count_d;
            state_q    <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign op_count  = op_count_q;
  assign dbg_data  = rf_q[dbg_addr];

endmodule
`default_nettype wire
